// File: rtl/l1cache_pkg.sv
// ============================================================================
// Module      : l1cache_pkg
// Description : Shared types and constants for the per-core L1 framebuffer
//               cache: framebuffer word/address types, L1 geometry and the
//               controller state encoding.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package l1cache_pkg;

    // Framebuffer word and address widths, shared with the L2 side.
    localparam int FB_ADDR_W = 16;
    localparam int FB_WORD_W = 16;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_WORD_W-1:0] fb_word_t;

    // Default L1 geometry: direct mapped, one word per line.
    localparam int L1_DEPTH     = 64;
    localparam int L1ADDRIDX_LO = 0;
    localparam int L1ADDRIDX_HI = $clog2(L1_DEPTH) - 1;
    localparam int L1ADDRTAG_LO = L1ADDRIDX_HI + 1;
    localparam int L1ADDRTAG_HI = FB_ADDR_W - 1;

    typedef logic [L1ADDRIDX_HI:L1ADDRIDX_LO] l1_idx_t;
    typedef logic [L1ADDRTAG_HI:L1ADDRTAG_LO] l1_tag_t;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MISS   = 2'd2,
        ST_WRITE  = 2'd3
    } l1_state_t;

endpackage

`default_nettype wire

// File: rtl/l1cache_tagmem.sv
// ============================================================================
// Module      : l1cache_tagmem
// Description : Valid/tag/data storage for the direct-mapped L1.
//               Ports: combinational read port (rd_*), fill/update write port
//               (wr_*; wr_set_valid marks the line valid on a fill), and an
//               invalidate-clear port (inv_*). Invalidation wins over a fill.
//               Only the valid bits are reset.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1cache_tagmem #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 10,
    parameter int DAT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    // read port
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [DAT_W-1:0] rd_data,
    // fill / update port
    input  logic             wr_en,
    input  logic             wr_set_valid,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [DAT_W-1:0] wr_data,
    // invalidate port
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx,
    input  logic [TAG_W-1:0] inv_tag
);

    logic [DEPTH-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [DEPTH];
    logic [DAT_W-1:0] r_data [DEPTH];

    logic w_fill;
    logic w_inv_hit;

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx];

    assign w_fill = wr_en && wr_set_valid;

    // Clear if the stored line matches, or if the line being filled this
    // very cycle carries the invalidated address (the fill must not survive).
    assign w_inv_hit = inv_en &&
                       ((r_valid[inv_idx] && (r_tag[inv_idx] == inv_tag)) ||
                        (w_fill && (wr_idx == inv_idx) && (wr_tag == inv_tag)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (w_fill) begin
                r_valid[wr_idx] <= 1'b1;
            end
            // Later assignment takes priority over the fill above.
            if (w_inv_hit) begin
                r_valid[inv_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_idx]  <= wr_tag;
            r_data[wr_idx] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/l1cache.sv
// ============================================================================
// Module      : l1cache
// Description : Per-core direct-mapped, write-through, no-write-allocate L1.
//               Core side : core_en/core_w/core_addr/core_d_in in,
//                           core_d_out/core_ready out.
//               L2 side   : l2_en/l2_w/l2_addr/l2_d_in out,
//                           l2_d_out/l2_ready in.
//               Snoop     : invalidate/inv_addr in, invalidated ack out.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1cache
    import l1cache_pkg::*;
#(
    parameter int DEPTH = L1_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     core_en,
    input  logic     core_w,
    input  fb_addr_t core_addr,
    input  fb_word_t core_d_in,
    output fb_word_t core_d_out,
    output logic     core_ready,
    output logic     l2_en,
    output logic     l2_w,
    output fb_addr_t l2_addr,
    output fb_word_t l2_d_in,
    input  fb_word_t l2_d_out,
    input  logic     l2_ready,
    input  logic     invalidate,
    input  fb_addr_t inv_addr,
    output logic     invalidated
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = FB_ADDR_W - IDX_W;

    l1_state_t r_state, w_next;
    fb_addr_t  r_addr;
    fb_word_t  r_wdata;
    logic      r_wr_done;
    logic      r_inv_ack;

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    fb_word_t         w_rd_data;
    logic             w_hit;
    logic             w_wr_en;
    logic             w_wr_set_valid;
    fb_word_t         w_wr_data;
    logic             w_inv_en;

    assign w_idx = r_addr[IDX_W-1:0];
    assign w_tag = r_addr[FB_ADDR_W-1:IDX_W];
    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    // In the cycle right after our own write completes, the L2 echoes that
    // write back as an invalidate; it must not kill the line we just updated.
    assign w_inv_en = invalidate && !(r_wr_done && (inv_addr == r_addr));

    assign invalidated = r_inv_ack;

    l1cache_tagmem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .DAT_W (FB_WORD_W)
    ) u_tagmem (
        .clk          (clk),
        .rst          (rst),
        .rd_idx       (w_idx),
        .rd_valid     (w_rd_valid),
        .rd_tag       (w_rd_tag),
        .rd_data      (w_rd_data),
        .wr_en        (w_wr_en),
        .wr_set_valid (w_wr_set_valid),
        .wr_idx       (w_idx),
        .wr_tag       (w_tag),
        .wr_data      (w_wr_data),
        .inv_en       (w_inv_en),
        .inv_idx      (inv_addr[IDX_W-1:0]),
        .inv_tag      (inv_addr[FB_ADDR_W-1:IDX_W])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr_done <= 1'b0;
            r_inv_ack <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wr_done <= (r_state == ST_WRITE) && l2_ready;
            r_inv_ack <= invalidate;
            if (w_accept) begin
                r_addr  <= core_addr;
                r_wdata <= core_d_in;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        core_ready     = 1'b0;
        core_d_out     = '0;
        l2_en          = 1'b0;
        l2_w           = 1'b0;
        l2_addr        = '0;
        l2_d_in        = '0;
        w_wr_en        = 1'b0;
        w_wr_set_valid = 1'b0;
        w_wr_data      = '0;
        case (r_state)
            ST_IDLE: begin
                if (core_en) begin
                    w_accept = 1'b1;
                    w_next   = core_w ? ST_WRITE : ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    core_ready = 1'b1;
                    core_d_out = w_rd_data;
                    w_next     = ST_IDLE;
                end else begin
                    w_next = ST_MISS;
                end
            end
            ST_MISS: begin
                l2_en   = 1'b1;
                l2_addr = r_addr;
                if (l2_ready) begin
                    w_wr_en        = 1'b1;
                    w_wr_set_valid = 1'b1;
                    w_wr_data      = l2_d_out;
                    core_ready     = 1'b1;
                    core_d_out     = l2_d_out;
                    w_next         = ST_IDLE;
                end
            end
            ST_WRITE: begin
                l2_en   = 1'b1;
                l2_w    = 1'b1;
                l2_addr = r_addr;
                l2_d_in = r_wdata;
                if (l2_ready) begin
                    // Write-through, no allocate: only a resident line is updated.
                    w_wr_en    = w_hit;
                    w_wr_data  = r_wdata;
                    core_ready = 1'b1;
                    w_next     = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_l1cache.sv
// ============================================================================
// Module      : tb_l1cache
// Description : Directed self-checking bench for l1cache. Inputs change 1ns
//               after the rising edge; outputs are checked 2ns after it.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l1cache;
    import l1cache_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     core_en, core_w;
    fb_addr_t core_addr, l2_addr, inv_addr;
    fb_word_t core_d_in, core_d_out, l2_d_in, l2_d_out;
    logic     core_ready, l2_en, l2_w, l2_ready, invalidate, invalidated;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l1cache #(.DEPTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .core_en     (core_en),
        .core_w      (core_w),
        .core_addr   (core_addr),
        .core_d_in   (core_d_in),
        .core_d_out  (core_d_out),
        .core_ready  (core_ready),
        .l2_en       (l2_en),
        .l2_w        (l2_w),
        .l2_addr     (l2_addr),
        .l2_d_in     (l2_d_in),
        .l2_d_out    (l2_d_out),
        .l2_ready    (l2_ready),
        .invalidate  (invalidate),
        .inv_addr    (inv_addr),
        .invalidated (invalidated)
    );

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; core_en = 0; core_w = 0; core_addr = '0; core_d_in = '0;
        l2_d_out = '0; l2_ready = 0; invalidate = 0; inv_addr = '0;
        tick(); tick();
        #1;
        total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL rst_core_ready got %b want 0", core_ready); end
        total++; if (l2_en !== 1'b0) begin bad++; $display("FAIL rst_l2_en got %b want 0", l2_en); end
        total++; if (invalidated !== 1'b0) begin bad++; $display("FAIL rst_invalidated got %b want 0", invalidated); end
        total++; if (l2_addr !== 16'h0000) begin bad++; $display("FAIL rst_l2_addr got %h want 0000", l2_addr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_miss_then_hit();
        core_en = 1; core_w = 0; core_addr = 16'h0100;
        #1;
        total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL miss_idle_ready got %b want 0", core_ready); end
        tick(); #1;   // LOOKUP, line invalid
        total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL miss_lookup_ready got %b want 0", core_ready); end
        tick(); #1;   // MISS, first cycle
        total++; if (l2_en !== 1'b1 || l2_w !== 1'b0) begin bad++; $display("FAIL miss_l2_req got en=%b w=%b want en=1 w=0", l2_en, l2_w); end
        total++; if (l2_addr !== 16'h0100) begin bad++; $display("FAIL miss_l2_addr got %h want 0100", l2_addr); end
        tick(); tick();
        l2_ready = 1; l2_d_out = 16'hABCD;
        #1;
        total++; if (core_ready !== 1'b1 || core_d_out !== 16'hABCD) begin bad++; $display("FAIL miss_fill got rdy=%b d=%h want rdy=1 d=abcd", core_ready, core_d_out); end
        core_en = 0;
        tick();
        l2_ready = 0;
        #1;
        total++; if (l2_en !== 1'b0) begin bad++; $display("FAIL miss_after_l2_en got %b want 0", l2_en); end
        // Re-read: hit two cycles after core_en with no L2 traffic.
        core_en = 1; core_addr = 16'h0100;
        tick(); #1;
        total++; if (core_ready !== 1'b1 || core_d_out !== 16'hABCD || l2_en !== 1'b0) begin bad++; $display("FAIL hit_reread got rdy=%b d=%h l2en=%b want rdy=1 d=abcd l2en=0", core_ready, core_d_out, l2_en); end
        core_en = 0;
        tick();
    endtask

    task automatic test_write_through();
        core_en = 1; core_w = 1; core_addr = 16'h0100; core_d_in = 16'h1234;
        tick(); #1;   // WRITE
        total++; if (l2_en !== 1'b1 || l2_w !== 1'b1 || l2_d_in !== 16'h1234 || l2_addr !== 16'h0100) begin bad++; $display("FAIL wr_req got en=%b w=%b d=%h a=%h want 1 1 1234 0100", l2_en, l2_w, l2_d_in, l2_addr); end
        tick();
        l2_ready = 1;
        #1;
        total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL wr_done_ready got %b want 1", core_ready); end
        core_en = 0; core_w = 0;
        tick();
        l2_ready = 0; invalidate = 1; inv_addr = 16'h0100;   // our own write echoed
        tick();
        invalidate = 0;
        #1;
        total++; if (invalidated !== 1'b1) begin bad++; $display("FAIL wr_self_inv_ack got %b want 1", invalidated); end
        core_en = 1; core_addr = 16'h0100;
        tick(); #1;
        total++; if (core_ready !== 1'b1 || core_d_out !== 16'h1234) begin bad++; $display("FAIL wr_then_hit got rdy=%b d=%h want rdy=1 d=1234", core_ready, core_d_out); end
        core_en = 0;
        tick();
    endtask

    task automatic test_external_invalidate();
        invalidate = 1; inv_addr = 16'h0100;
        tick();
        invalidate = 0;
        #1;
        total++; if (invalidated !== 1'b1) begin bad++; $display("FAIL ext_inv_ack got %b want 1", invalidated); end
        tick(); #1;
        total++; if (invalidated !== 1'b0) begin bad++; $display("FAIL ext_inv_ack_drop got %b want 0", invalidated); end
        core_en = 1; core_addr = 16'h0100;
        tick(); #1;   // LOOKUP must miss
        total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL ext_inv_miss_ready got %b want 0", core_ready); end
        tick(); #1;
        total++; if (l2_en !== 1'b1) begin bad++; $display("FAIL ext_inv_miss_l2_en got %b want 1", l2_en); end
        l2_ready = 1; l2_d_out = 16'h5555;
        #1;
        core_en = 0;
        tick();
        l2_ready = 0;
    endtask

    task automatic test_invalidate_other_tag();
        invalidate = 1; inv_addr = 16'h0140;   // same index, different tag
        tick();
        invalidate = 0;
        #1;
        total++; if (invalidated !== 1'b1) begin bad++; $display("FAIL oth_tag_ack got %b want 1", invalidated); end
        core_en = 1; core_addr = 16'h0100;
        tick(); #1;
        total++; if (core_ready !== 1'b1 || core_d_out !== 16'h5555) begin bad++; $display("FAIL oth_tag_hit got rdy=%b d=%h want rdy=1 d=5555", core_ready, core_d_out); end
        core_en = 0;
        tick();
    endtask

    task automatic test_fill_with_invalidate();
        core_en = 1; core_addr = 16'h0200;
        tick(); tick();   // LOOKUP, then MISS
        l2_ready = 1; l2_d_out = 16'h7777; invalidate = 1; inv_addr = 16'h0200;
        #1;
        total++; if (core_ready !== 1'b1 || core_d_out !== 16'h7777) begin bad++; $display("FAIL fillinv_data got rdy=%b d=%h want rdy=1 d=7777", core_ready, core_d_out); end
        core_en = 0;
        tick();
        l2_ready = 0; invalidate = 0;
        core_en = 1; core_addr = 16'h0200;
        tick(); #1;
        total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL fillinv_reread_ready got %b want 0", core_ready); end
        tick(); #1;
        total++; if (l2_en !== 1'b1 || l2_addr !== 16'h0200) begin bad++; $display("FAIL fillinv_reread_l2 got en=%b a=%h want en=1 a=0200", l2_en, l2_addr); end
        l2_ready = 1; l2_d_out = 16'h7778;
        #1;
        core_en = 0;
        tick();
        l2_ready = 0;
    endtask

    task automatic test_back_to_back_invalidate();
        invalidate = 1; inv_addr = 16'h0033;
        tick();
        inv_addr = 16'h0034;
        #1;
        total++; if (invalidated !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got %b want 1", invalidated); end
        tick();
        invalidate = 0;
        #1;
        total++; if (invalidated !== 1'b1) begin bad++; $display("FAIL b2b_ack2 got %b want 1", invalidated); end
        tick(); #1;
        total++; if (invalidated !== 1'b0) begin bad++; $display("FAIL b2b_ack_end got %b want 0", invalidated); end
    endtask

    task automatic test_reset_mid_miss();
        core_en = 1; core_addr = 16'h0300;
        tick(); tick(); #1;
        total++; if (l2_en !== 1'b1) begin bad++; $display("FAIL rmm_pre_l2_en got %b want 1", l2_en); end
        rst = 1;
        #1;
        total++; if (l2_en !== 1'b0 || core_ready !== 1'b0) begin bad++; $display("FAIL rmm_async got en=%b rdy=%b want 0 0", l2_en, core_ready); end
        core_en = 0;
        tick();
        rst = 0;
        tick();
        // 0x0200 was cached before the reset; it must miss now.
        core_en = 1; core_addr = 16'h0200;
        tick(); #1;
        total++; if (core_ready !== 1'b0) begin bad++; $display("FAIL rmm_after_ready got %b want 0", core_ready); end
        tick(); #1;
        total++; if (l2_en !== 1'b1 || l2_addr !== 16'h0200) begin bad++; $display("FAIL rmm_after_l2 got en=%b a=%h want en=1 a=0200", l2_en, l2_addr); end
        l2_ready = 1; l2_d_out = 16'h0042;
        #1;
        core_en = 0;
        tick();
        l2_ready = 0;
    endtask

    initial begin
        test_reset();
        test_read_miss_then_hit();
        test_write_through();
        test_external_invalidate();
        test_invalidate_other_tag();
        test_fill_with_invalidate();
        test_back_to_back_invalidate();
        test_reset_mid_miss();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
